// File: rtl/tinyfpga_pkg.sv
// Shared constants and configuration-chain field layouts for the tiny FPGA fabric.
package tinyfpga_pkg;
  localparam int NUM_LE      = 8;
  localparam int LUT_K       = 4;
  localparam int NUM_IO      = 8;
  localparam int SEL_W       = 4;
  localparam int LUT_W       = 2 ** LUT_K;
  localparam int NUM_SRC     = 2 * NUM_IO;
  localparam int LE_CFG_W    = LUT_K * SEL_W + LUT_W + 1;
  localparam int IO_CFG_W    = SEL_W + 1;
  localparam int IO_CFG_BASE = NUM_LE * LE_CFG_W;
  localparam int CFG_LEN     = IO_CFG_BASE + NUM_IO * IO_CFG_W;

  // Packed MSB-first so the struct overlays the chain slice directly: sel[0] sits just above lut.
  typedef struct packed {
    logic                        ff_en;
    logic [LUT_K-1:0][SEL_W-1:0] sel;
    logic [LUT_W-1:0]            lut;
  } le_cfg_t;

  typedef struct packed {
    logic             oe;
    logic [SEL_W-1:0] sel;
  } io_cfg_t;

  function automatic int le_cfg_base(input int j);
    return j * LE_CFG_W;
  endfunction

  function automatic int io_cfg_base(input int k);
    return IO_CFG_BASE + k * IO_CFG_W;
  endfunction
endpackage

// File: rtl/tinyfpga_if.sv
// TinyTapeout slot pins of the tiny FPGA, grouped as one bundle.
interface tinyfpga_if;
  import tinyfpga_pkg::*;
  logic              ena;
  logic [7:0]        ui_in;
  logic [7:0]        uo_out;
  logic [NUM_IO-1:0] uio_in;
  logic [NUM_IO-1:0] uio_out;
  logic [NUM_IO-1:0] uio_oe;

  modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/tinyfpga_le.sv
// One LUT4 logic element: four routing muxes, LUT, optional output FF.
module tinyfpga_le
  import tinyfpga_pkg::*;
#(
  parameter int J = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  le_cfg_t           cfg,
  input  logic [NUM_IO-1:0] pin_src,
  input  logic [NUM_LE-1:0] o_in,
  input  logic [NUM_LE-1:0] q_in,
  output logic              o,
  output logic              q
);
  logic [NUM_LE-1:0]  fb;
  logic [NUM_SRC-1:0] src;
  wire  [LUT_K-1:0]   lut_idx;
  logic               lut_out;
  logic               q_d, q_q;

  // Lower-indexed LEs may feed us combinationally; everything else only through its FF.
  always_comb begin
    fb = '0;
    for (int i = 0; i < NUM_LE; i++) begin
      fb[i] = (i < J) ? o_in[i] : q_in[i];
    end
  end

  assign src = {fb, pin_src};

  for (genvar gi = 0; gi < LUT_K; gi++) begin : g_in
    assign lut_idx[gi] = src[cfg.sel[gi]];
  end

  assign lut_out = cfg.lut[lut_idx];

  always_comb begin
    q_d = q_q;
    if (run) begin
      q_d = lut_out;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign o = cfg.ff_en ? q_q : lut_out;
  assign q = q_q;
endmodule

// File: rtl/tt_um_riceshelley_tiny_fpga.sv
// Tiny scan-configured FPGA: 8 LUT4 LEs and 8 uio pins, configured over a 304-bit chain driven from ui_in.
// Define FPGA_INPUT_SYNC_EN to pass uio_in through a 2-FF synchronizer before routing.
module tt_um_riceshelley_tiny_fpga
  import tinyfpga_pkg::*;
(
  input logic       clk,
  input logic       rst,
  tinyfpga_if.slave bus
);
  logic [3:0]         prog_s1_q, prog_s1_d, prog_s2_q, prog_s2_d;
  logic               pclk_dly_q, pclk_dly_d;
  logic [CFG_LEN-1:0] cfg_q, cfg_d;
  logic               prog_rst_s, prog_en_s, prog_data_s, shift_stb, le_run;
  logic [NUM_IO-1:0]  uio_src;
  wire  [NUM_LE-1:0]  le_o, le_q;
  logic [NUM_SRC-1:0] pin_pool;
  wire  [NUM_IO-1:0]  uio_out_w, uio_oe_w;
  logic               unused_ui;

  assign prog_rst_s  = prog_s2_q[1];
  assign prog_en_s   = prog_s2_q[2];
  assign prog_data_s = prog_s2_q[3];
  assign shift_stb   = prog_s2_q[0] & ~pclk_dly_q;
  assign le_run      = bus.ena & ~prog_en_s;
  assign unused_ui   = &{1'b0, bus.ui_in[7:4]};

  // progClk is just an oversampled data pin; a synced rising edge is the shift strobe.
  always_comb begin
    prog_s1_d  = prog_s1_q;
    prog_s2_d  = prog_s2_q;
    pclk_dly_d = pclk_dly_q;
    cfg_d      = cfg_q;
    if (bus.ena) begin
      prog_s1_d  = bus.ui_in[3:0];
      prog_s2_d  = prog_s1_q;
      pclk_dly_d = prog_s2_q[0];
      if (prog_rst_s) begin
        cfg_d = '0;
      end else if (shift_stb && prog_en_s) begin
        cfg_d = {cfg_q[CFG_LEN-2:0], prog_data_s};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prog_s1_q  <= '0;
      prog_s2_q  <= '0;
      pclk_dly_q <= 1'b0;
      cfg_q      <= '0;
    end else begin
      prog_s1_q  <= prog_s1_d;
      prog_s2_q  <= prog_s2_d;
      pclk_dly_q <= pclk_dly_d;
      cfg_q      <= cfg_d;
    end
  end

`ifdef FPGA_INPUT_SYNC_EN
  logic [NUM_IO-1:0] uio_s1_q, uio_s1_d, uio_s2_q, uio_s2_d;

  always_comb begin
    uio_s1_d = uio_s1_q;
    uio_s2_d = uio_s2_q;
    if (bus.ena) begin
      uio_s1_d = bus.uio_in;
      uio_s2_d = uio_s1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      uio_s1_q <= '0;
      uio_s2_q <= '0;
    end else begin
      uio_s1_q <= uio_s1_d;
      uio_s2_q <= uio_s2_d;
    end
  end

  assign uio_src = uio_s2_q;
`else
  assign uio_src = bus.uio_in;
`endif

  // Each LE gets its own vector of lower-LE outputs so the feed-forward chain never forms a loop.
  for (genvar gi = 0; gi < NUM_LE; gi++) begin : g_le
    wire  [NUM_LE-1:0] o_lo;
    logic              o_w, q_w;
    le_cfg_t           le_cfg;

    for (genvar gk = 0; gk < NUM_LE; gk++) begin : g_lo
      if (gk < gi) begin : g_fwd
        assign o_lo[gk] = g_le[gk].o_w;
      end else begin : g_tie
        assign o_lo[gk] = 1'b0;
      end
    end

    assign le_cfg = le_cfg_t'(cfg_q[le_cfg_base(gi) +: LE_CFG_W]);

    tinyfpga_le #(.J(gi)) u_le (
      .clk     (clk),
      .rst     (rst),
      .run     (le_run),
      .cfg     (le_cfg),
      .pin_src (uio_src),
      .o_in    (o_lo),
      .q_in    (le_q),
      .o       (o_w),
      .q       (q_w)
    );

    assign le_o[gi] = o_w;
    assign le_q[gi] = q_w;
  end

  assign pin_pool = {le_o, uio_src};

  for (genvar gi = 0; gi < NUM_IO; gi++) begin : g_pin
    io_cfg_t pin_cfg;
    assign pin_cfg       = io_cfg_t'(cfg_q[io_cfg_base(gi) +: IO_CFG_W]);
    assign uio_out_w[gi] = pin_pool[pin_cfg.sel];
    assign uio_oe_w[gi]  = pin_cfg.oe;
  end

  assign bus.uio_out = uio_out_w;
  assign bus.uio_oe  = uio_oe_w;
  assign bus.uo_out  = {7'b0, cfg_q[CFG_LEN-1]};
endmodule

// File: tb/tb_tt_um_riceshelley_tiny_fpga.sv
// Scoreboard bench for the tiny FPGA: serial config loading, loopback, and small fabric circuits.
module tb_tt_um_riceshelley_tiny_fpga;
  localparam int CFG_BITS = 304;
`ifdef FPGA_INPUT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;
  logic [CFG_BITS-1:0] cfg_img;

  tinyfpga_if bus ();

  tt_um_riceshelley_tiny_fpga dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bit(input logic b, input logic en);
    bus.ui_in[3] = b;
    bus.ui_in[2] = en;
    bus.ui_in[0] = 1'b0;
    repeat (4) tick();
    bus.ui_in[0] = 1'b1;
    repeat (4) tick();
  endtask

  task automatic end_prog();
    bus.ui_in[0] = 1'b0;
    bus.ui_in[2] = 1'b0;
    repeat (4) tick();
  endtask

  task automatic load_cfg(input string name);
    for (int b = CFG_BITS - 1; b >= 0; b--) shift_bit(cfg_img[b], 1'b1);
    end_prog();
    $display("loaded config %s", name);
  endtask

  function automatic void set_le(input int j, input logic [15:0] lut, input logic [3:0] s0,
                                 input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] s3,
                                 input logic ff);
    cfg_img[33*j +: 16]    = lut;
    cfg_img[33*j+16 +: 4]  = s0;
    cfg_img[33*j+20 +: 4]  = s1;
    cfg_img[33*j+24 +: 4]  = s2;
    cfg_img[33*j+28 +: 4]  = s3;
    cfg_img[33*j+32]       = ff;
  endfunction

  function automatic void set_pin(input int k, input logic [3:0] sel, input logic oe);
    cfg_img[264+5*k +: 4] = sel;
    cfg_img[264+5*k+4]    = oe;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.ena = 1'b1;
    bus.ui_in = 8'hA0;
    bus.uio_in = 8'h00;
    repeat (2) tick();
    exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    exp_v = exp_q.pop_front(); n_checks++;
    if (bus.uo_out !== exp_v) begin n_fail++; $display("FAIL reset_uo_out: got %h required %h", bus.uo_out, exp_v); end
    exp_v = exp_q.pop_front(); n_checks++;
    if (bus.uio_oe !== exp_v) begin n_fail++; $display("FAIL reset_uio_oe: got %h required %h", bus.uio_oe, exp_v); end
    exp_v = exp_q.pop_front(); n_checks++;
    if (bus.uio_out !== exp_v) begin n_fail++; $display("FAIL reset_uio_out: got %h required %h", bus.uio_out, exp_v); end
    rst = 1'b0;
    tick();
    $display("reset checked");
  endtask

  task automatic test_loopback();
    logic [7:0] lfsr;
    logic b;
    logic first_b;
    lfsr = 8'hA5;
    first_b = 1'b0;
    for (int i = 0; i < CFG_BITS; i++) begin
      b = lfsr[0];
      if (i == 0) first_b = b;
      exp_q.push_back({7'b0, b});
      shift_bit(b, 1'b1);
      lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
    // progClk pulses without progEn must leave the chain alone
    shift_bit(~first_b, 1'b0);
    shift_bit(~first_b, 1'b0);
    n_checks++;
    if (bus.uo_out !== {7'b0, first_b}) begin
      n_fail++; $display("FAIL loopback_hold: got %h required %h", bus.uo_out, {7'b0, first_b});
    end
    for (int i = 0; i < CFG_BITS; i++) begin
      exp_v = exp_q.pop_front(); n_checks++;
      if (bus.uo_out !== exp_v) begin
        n_fail++; $display("FAIL loopback_bit%0d: got %h required %h", i, bus.uo_out, exp_v);
      end
      shift_bit(1'b0, 1'b1);
    end
    exp_q.push_back(8'h00);
    exp_v = exp_q.pop_front(); n_checks++;
    if (bus.uo_out !== exp_v) begin n_fail++; $display("FAIL loopback_flushed: got %h required %h", bus.uo_out, exp_v); end
    end_prog();
    $display("loopback of %0d bits checked", CFG_BITS);
  endtask

  task automatic test_passthrough();
    logic [7:0] vals [5];
    vals = '{8'h01, 8'h00, 8'hFF, 8'hFE, 8'h55};
    cfg_img = '0;
    set_pin(0, 4'd0, 1'b1);
    load_cfg("passthrough");
    exp_q.push_back(8'h01);
    exp_v = exp_q.pop_front(); n_checks++;
    if (bus.uio_oe !== exp_v) begin n_fail++; $display("FAIL pass_oe: got %h required %h", bus.uio_oe, exp_v); end
    foreach (vals[i]) begin
      bus.uio_in = vals[i];
      exp_q.push_back({7'b0, vals[i][0]});
      repeat (LAT) tick();
      #1;
      exp_v = exp_q.pop_front(); n_checks++;
      if ({7'b0, bus.uio_out[0]} !== exp_v) begin
        n_fail++; $display("FAIL pass_out uio_in=%h: got %b required %b", vals[i], bus.uio_out[0], exp_v[0]);
      end
      $display("passthrough uio_in=%h uio_out[0]=%b", vals[i], bus.uio_out[0]);
    end
  endtask

  task automatic test_and2();
    logic [7:0] vals [5];
    vals = '{8'h03, 8'h01, 8'h02, 8'hFF, 8'h00};
    cfg_img = '0;
    set_le(0, 16'h8888, 4'd0, 4'd1, 4'd0, 4'd0, 1'b0);
    set_pin(3, 4'd8, 1'b1);
    load_cfg("and2");
    exp_q.push_back(8'h08);
    exp_v = exp_q.pop_front(); n_checks++;
    if (bus.uio_oe !== exp_v) begin n_fail++; $display("FAIL and2_oe: got %h required %h", bus.uio_oe, exp_v); end
    foreach (vals[i]) begin
      bus.uio_in = vals[i];
      exp_q.push_back({7'b0, vals[i][0] & vals[i][1]});
      repeat (LAT) tick();
      #1;
      exp_v = exp_q.pop_front(); n_checks++;
      if ({7'b0, bus.uio_out[3]} !== exp_v) begin
        n_fail++; $display("FAIL and2_out uio_in=%h: got %b required %b", vals[i], bus.uio_out[3], exp_v[0]);
      end
      $display("and2 uio_in=%h uio_out[3]=%b", vals[i], bus.uio_out[3]);
    end
  endtask

  task automatic test_toggler();
    logic a;
    cfg_img = '0;
    set_le(0, 16'h5555, 4'd8, 4'd0, 4'd0, 4'd0, 1'b1);
    set_pin(7, 4'd8, 1'b1);
    load_cfg("toggler");
    // q0 is 0 entering the load and toggles twice after progEn drops inside end_prog
    exp_q.push_back(8'h80); exp_q.push_back(8'h01);
    exp_v = exp_q.pop_front(); n_checks++;
    if (bus.uio_oe !== exp_v) begin n_fail++; $display("FAIL tog_oe: got %h required %h", bus.uio_oe, exp_v); end
    exp_v = exp_q.pop_front(); n_checks++;
    if (bus.uo_out !== exp_v) begin n_fail++; $display("FAIL tog_prog_out: got %h required %h", bus.uo_out, exp_v); end
    a = 1'b0;
    for (int i = 0; i < 13; i++) begin
      if (i == 6) bus.ena = 1'b0;
      if (i == 10) bus.ena = 1'b1;
      if (i > 0) begin
        if (bus.ena) a = ~a;
        tick();
      end
      exp_q.push_back({7'b0, a});
      exp_v = exp_q.pop_front(); n_checks++;
      if ({7'b0, bus.uio_out[7]} !== exp_v) begin
        n_fail++; $display("FAIL tog_step%0d ena=%b: got %b required %b", i, bus.ena, bus.uio_out[7], exp_v[0]);
      end
      $display("toggler step %0d ena=%b uio_out[7]=%b", i, bus.ena, bus.uio_out[7]);
    end
  endtask

  task automatic test_prog_rst();
    bus.ui_in[1] = 1'b1;
    repeat (4) tick();
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    exp_v = exp_q.pop_front(); n_checks++;
    if (bus.uio_oe !== exp_v) begin n_fail++; $display("FAIL progrst_oe: got %h required %h", bus.uio_oe, exp_v); end
    exp_v = exp_q.pop_front(); n_checks++;
    if (bus.uo_out !== exp_v) begin n_fail++; $display("FAIL progrst_uo: got %h required %h", bus.uo_out, exp_v); end
    bus.ui_in[1] = 1'b0;
    repeat (4) tick();
    $display("progRst cleared chain");
  endtask

  task automatic test_rst_midshift();
    cfg_img = '1;
    load_cfg("all_ones");
    exp_q.push_back(8'hFF); exp_q.push_back(8'h01);
    exp_v = exp_q.pop_front(); n_checks++;
    if (bus.uio_oe !== exp_v) begin n_fail++; $display("FAIL ones_oe: got %h required %h", bus.uio_oe, exp_v); end
    exp_v = exp_q.pop_front(); n_checks++;
    if (bus.uo_out !== exp_v) begin n_fail++; $display("FAIL ones_uo: got %h required %h", bus.uo_out, exp_v); end
    bus.uio_in = 8'h00;
    for (int i = 0; i < 5; i++) shift_bit(1'b0, 1'b1);
    rst = 1'b1;
    repeat (2) tick();
    exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    exp_v = exp_q.pop_front(); n_checks++;
    if (bus.uo_out !== exp_v) begin n_fail++; $display("FAIL midrst_uo: got %h required %h", bus.uo_out, exp_v); end
    exp_v = exp_q.pop_front(); n_checks++;
    if (bus.uio_oe !== exp_v) begin n_fail++; $display("FAIL midrst_oe: got %h required %h", bus.uio_oe, exp_v); end
    exp_v = exp_q.pop_front(); n_checks++;
    if (bus.uio_out !== exp_v) begin n_fail++; $display("FAIL midrst_out: got %h required %h", bus.uio_out, exp_v); end
    rst = 1'b0;
    bus.ui_in = 8'h00;
    tick();
    $display("reset mid-shift checked");
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_passthrough();
    test_and2();
    test_toggler();
    test_prog_rst();
    test_rst_midshift();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
